// File: rtl/wave_defs.sv
// Shared definitions for the wave_capture / wave_display pair: window origin,
// FSM encodings and sample RAM address width.
package wave_defs;
    localparam int X_START_DEF = 64;
    localparam int Y_TOP_DEF   = 112;
    localparam int ADDR_W      = 9;
    localparam int WIN_W       = 512;
    localparam int WIN_H       = 256;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_t;
endpackage

// File: rtl/wave_display_if.sv
// Pixel-stream and sample-RAM signals between the video/capture side and wave_display.
interface wave_display_if;
    import wave_defs::*;

    logic [10:0]       x;
    logic [9:0]        y;
    logic              valid;
    logic              read_index;
    logic [7:0]        read_value;
    logic [ADDR_W-1:0] read_address;
    logic              valid_pixel;
    logic [7:0]        r;
    logic [7:0]        g;
    logic [7:0]        b;
    logic              wave_display_idle;

    modport master (
        output x, y, valid, read_index, read_value,
        input  read_address, valid_pixel, r, g, b, wave_display_idle
    );

    modport slave (
        input  x, y, valid, read_index, read_value,
        output read_address, valid_pixel, r, g, b, wave_display_idle
    );
endinterface

// File: rtl/wave_display_pixel_test.sv
// Lit decision for one pixel: row falls inside the segment joining two samples.
module wave_pixel_test (
    input  logic [7:0] row,
    input  logic [7:0] srow,
    input  logic [7:0] prev_srow,
    output logic       lit
);
    logic [7:0] lo;
    logic [7:0] hi;

    always_comb begin
        lo  = (srow < prev_srow) ? srow : prev_srow;
        hi  = (srow < prev_srow) ? prev_srow : srow;
        lit = (row >= lo) && (row <= hi);
    end
endmodule

// File: rtl/wave_display.sv
// Renders the 256-sample frame from the sample RAM as a joined scope trace
// inside a 512x256 window of the VGA pixel stream (2-cycle pixel latency).
//
// state | meaning
// IDLE  | RAM not in use; waiting for the window's first pixel
// DRAW  | frame in progress; bank frozen until the window's last pixel
module wave_display
    import wave_defs::*;
#(
    parameter int          X_START  = X_START_DEF,
    parameter int          Y_TOP    = Y_TOP_DEF,
    parameter logic [23:0] WAVE_RGB = 24'hFFFFFF
) (
    input  logic          clk,
    input  logic          reset,
    wave_display_if.slave bus
);
    localparam logic [10:0] X0 = 11'(X_START);
    localparam logic [10:0] X1 = 11'(X_START + WIN_W - 1);
    localparam logic [9:0]  Y0 = 10'(Y_TOP);
    localparam logic [9:0]  Y1 = 10'(Y_TOP + WIN_H - 1);

    state_t            state, state_nxt;
    logic              draw_en;
    logic              in_win, frame_start, frame_end;
    logic [7:0]        col, row;
    logic              bank, bank_eff;
    logic              idle_q;
    logic [ADDR_W-1:0] read_address_q;
    logic              win_s1;
    logic [7:0]        row_s1, col_s1;
    logic [7:0]        srow, prev_srow;
    logic [7:0]        cur_col, cur_srow, prev_q;
    logic              lit_raw;
    logic              lit_q;
    logic [23:0]       rgb_q;

    assign in_win      = bus.valid && (bus.x >= X0) && (bus.x <= X1)
                                   && (bus.y >= Y0) && (bus.y <= Y1);
    assign frame_start = bus.valid && (bus.x == X0) && (bus.y == Y0);
    assign frame_end   = bus.valid && (bus.x == X1) && (bus.y == Y1);
    assign col         = 8'((bus.x - X0) >> 1);
    assign row         = 8'(bus.y - Y0);
    // The frame-start pixel is drawn from the incoming bank, before it is latched.
    assign bank_eff    = (state == IDLE) ? bus.read_index : bank;

    always_comb begin
        state_nxt = state;
        draw_en   = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_nxt = DRAW;
                    draw_en   = 1'b1;
                end
            end
            DRAW: begin
                draw_en = 1'b1;
                if (frame_end) state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            bank           <= 1'b0;
            idle_q         <= 1'b1;
            read_address_q <= '0;
            win_s1         <= 1'b0;
            row_s1         <= '0;
            col_s1         <= '0;
        end else begin
            state  <= state_nxt;
            idle_q <= (state_nxt == IDLE);
            if ((state == IDLE) && frame_start) bank <= bus.read_index;
            win_s1 <= in_win && draw_en;
            row_s1 <= row;
            col_s1 <= col;
            if (in_win && draw_en) read_address_q <= {bank_eff, col};
        end
    end

    assign srow = 8'hFF - bus.read_value;

    // Column 0 starts a fresh trace on every row, so it is drawn as a single dot.
    always_comb begin
        prev_srow = prev_q;
        if (col_s1 == 8'd0)
            prev_srow = srow;
        else if (col_s1 != cur_col)
            prev_srow = cur_srow;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_col  <= '0;
            cur_srow <= '0;
            prev_q   <= '0;
        end else if (win_s1) begin
            cur_col  <= col_s1;
            cur_srow <= srow;
            if (col_s1 != cur_col) prev_q <= cur_srow;
        end
    end

    wave_pixel_test u_pixel_test (
        .row       (row_s1),
        .srow      (srow),
        .prev_srow (prev_srow),
        .lit       (lit_raw)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lit_q <= 1'b0;
            rgb_q <= '0;
        end else begin
            lit_q <= win_s1 && lit_raw;
            rgb_q <= (win_s1 && lit_raw) ? WAVE_RGB : 24'h000000;
        end
    end

    assign bus.read_address      = read_address_q;
    assign bus.wave_display_idle = idle_q;
    assign bus.valid_pixel       = lit_q;
    assign {bus.r, bus.g, bus.b} = rgb_q;
endmodule

// File: tb/tb_wave_display.sv
// Directed bench for wave_display: sparse-row frame sweeps against a scoreboard
// model of the window, bank latch, idle handshake and 2-cycle pixel pipeline.
module tb_wave_display;
    logic clk = 1'b0;
    logic reset;

    wave_display_if bus ();

    wave_display #(
        .X_START  (64),
        .Y_TOP    (112),
        .WAVE_RGB (24'hFFFFFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  ram [0:511];
    assign bus.read_value = ram[bus.read_address];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [24:0] exp_q [$];
    logic        m_draw   = 1'b0;
    logic        m_bank   = 1'b0;
    logic        m_idle   = 1'b1;
    logic [8:0]  m_addr   = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int px, input int py, input bit pv);
        logic [24:0] e;
        logic [7:0]  c8, s, p;
        bit          in_win, start, fin, was_draw, lit;
        int          rw;
        @(posedge clk);
        #1;
        chk("idle", {31'd0, bus.wave_display_idle}, {31'd0, m_idle});
        chk("read_address", {23'd0, bus.read_address}, {23'd0, m_addr});
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            chk("valid_pixel", {31'd0, bus.valid_pixel}, {31'd0, e[24]});
            chk("rgb", {8'd0, bus.r, bus.g, bus.b}, {8'd0, e[23:0]});
        end
        bus.x     = 11'(px);
        bus.y     = 10'(py);
        bus.valid = pv;
        in_win = pv && px >= 64 && px <= 575 && py >= 112 && py <= 367;
        start  = pv && px == 64 && py == 112;
        fin    = pv && px == 575 && py == 367;
        was_draw = m_draw;
        if (!was_draw && start) begin
            m_bank = bus.read_index;
            m_draw = 1'b1;
        end else if (was_draw && fin) begin
            m_draw = 1'b0;
        end
        lit = 1'b0;
        if (in_win && (was_draw || start)) begin
            c8 = 8'((px - 64) / 2);
            rw = py - 112;
            m_addr = {m_bank, c8};
            s = 8'hFF - ram[{m_bank, c8}];
            p = (c8 == 8'd0) ? s : 8'hFF - ram[{m_bank, 8'(c8 - 8'd1)}];
            lit = (rw >= int'(s) && rw <= int'(p)) || (rw >= int'(p) && rw <= int'(s));
        end
        m_idle = !m_draw;
        exp_q.push_back({lit, lit ? 24'hFFFFFF : 24'h000000});
    endtask

    task automatic sweep_row(input int r, input int glitch_x);
        for (int xx = 64; xx <= 575; xx++) step(xx, 112 + r, xx != glitch_x);
        step(0, 0, 0);
        step(0, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        bus.x          = '0;
        bus.y          = '0;
        bus.valid      = 1'b0;
        bus.read_index = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ram[i]       = 8'h80;
            ram[256 + i] = 8'h40;
        end

        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_idle", {31'd0, bus.wave_display_idle}, 32'd1);
        chk("rst_addr", {23'd0, bus.read_address}, 32'd0);
        chk("rst_rgb", {8'd0, bus.r, bus.g, bus.b}, 32'd0);
        chk("rst_valid_pixel", {31'd0, bus.valid_pixel}, 32'd0);
        reset = 1'b0;
        repeat (4) step(0, 0, 0);
        step(64, 112, 0);
        repeat (3) step(0, 0, 0);

        // Flat zero wave, with a blanking glitch inside row 127
        sweep_row(0, -1);
        sweep_row(126, -1);
        sweep_row(127, 200);
        sweep_row(128, -1);
        sweep_row(255, -1);
        repeat (4) step(0, 0, 0);

        // Step wave; the final pixel first arrives with valid low
        for (int i = 0; i < 256; i++) ram[i] = (i < 128) ? 8'hFF : 8'h00;
        sweep_row(0, -1);
        sweep_row(1, -1);
        sweep_row(127, -1);
        sweep_row(200, -1);
        sweep_row(255, 575);
        chk("glitch_end_idle", {31'd0, bus.wave_display_idle}, 32'd0);
        step(575, 367, 1);
        repeat (4) step(0, 0, 0);

        // Bank toggled mid-frame, picked up at the next frame start
        sweep_row(0, -1);
        sweep_row(50, -1);
        bus.read_index = 1'b1;
        sweep_row(100, -1);
        sweep_row(255, -1);
        repeat (4) step(0, 0, 0);
        sweep_row(0, -1);
        chk("bank_latched", {31'd0, bus.read_address[8]}, 32'd1);
        sweep_row(191, -1);
        bus.read_index = 1'b0;
        sweep_row(255, -1);
        repeat (4) step(0, 0, 0);

        // Asynchronous reset while column 128 of row 50 is on the output
        sweep_row(0, -1);
        for (int xx = 64; xx <= 322; xx++) step(xx, 162, 1);
        chk("pre_reset_lit", {31'd0, bus.valid_pixel}, 32'd1);
        reset = 1'b1;
        #1;
        chk("async_valid_pixel", {31'd0, bus.valid_pixel}, 32'd0);
        chk("async_rgb", {8'd0, bus.r, bus.g, bus.b}, 32'd0);
        chk("async_idle", {31'd0, bus.wave_display_idle}, 32'd1);
        chk("async_addr", {23'd0, bus.read_address}, 32'd0);
        m_draw = 1'b0;
        m_bank = 1'b0;
        m_idle = 1'b1;
        m_addr = '0;
        foreach (exp_q[i]) exp_q[i] = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int xx = 323; xx <= 575; xx++) step(xx, 162, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        sweep_row(51, -1);
        sweep_row(255, -1);
        repeat (4) step(0, 0, 0);

        // Drawing resumes at the next frame start
        sweep_row(0, -1);
        sweep_row(50, -1);
        sweep_row(255, -1);
        repeat (4) step(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
